// File: rtl/multicycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_if
//
// Purpose:
//   Shared-memory-port handshake between the multi-cycle sequencer and the
//   single memory port of the RV32I datapath. One address mux select, one read
//   strobe, one write strobe and one completion flag from the memory side.
//
// Signals:
//   ifetch     sequencer -> memory  address mux select (1 = PC, FETCH only)
//   mem_read   sequencer -> memory  read strobe
//   mem_write  sequencer -> memory  write strobe
//   mem_ready  memory -> sequencer  current access completes this cycle
//
// Modports:
//   master  the sequencer (drives strobes, observes mem_ready)
//   slave   the memory port (observes strobes, drives mem_ready)
// -----------------------------------------------------------------------------
interface multicycle_sequencer_if;
  logic ifetch;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (
    output ifetch,
    output mem_read,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  ifetch,
    input  mem_read,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Purpose:
//   Timing/enable FSM for a multi-cycle RV32I datapath. Each instruction walks
//   FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK). The combinational
//   controller beside this block still provides ALU op/source, access length
//   and sign; this block only decides *when* things happen.
//
// Parameters:
//   MEM_TIMEOUT  consecutive not-ready cycles in FETCH/MEMORY before HALT with
//                timeout=1 (2..255)
//   CNT_W        width of the wait counter; must hold MEM_TIMEOUT-1
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset (highest priority)
//   run          start/continue fetching; sampled only in IDLE and at retire
//   opcode       IR[6:0], stable from DECODE through retire
//   take_branch  branch decision, meaningful in EXECUTE
//   bus          memory-port handshake (ifetch, mem_read, mem_write, mem_ready)
//   ir_write     load IR (Mealy: FETCH and mem_ready)
//   pc_write     update PC this cycle (Mealy in MEMORY for stores)
//   pc_sel       PC source: 0 = PC+4, 1 = target
//   reg_write    register-file write enable (WRITEBACK only)
//   state        current state encoding
//   illegal      sticky: unsupported opcode seen in DECODE
//   timeout      sticky: memory did not answer within MEM_TIMEOUT cycles
//   instr_count  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [6:0]                    opcode,
  input  logic                          take_branch,
  multicycle_sequencer_if.master        bus,
  output logic                          ir_write,
  output logic                          pc_write,
  output logic                          pc_sel,
  output logic                          reg_write,
  output logic [2:0]                    state,
  output logic                          illegal,
  output logic                          timeout,
  output logic [31:0]                   instr_count
);

  // State encodings are externally visible on the state port.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  // Instruction classes latched in DECODE.
  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_I      = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LUI    = 4'd5;
  localparam logic [3:0] CLS_AUIPC  = 4'd6;
  localparam logic [3:0] CLS_JAL    = 4'd7;
  localparam logic [3:0] CLS_JALR   = 4'd8;

  // Last count value before a not-ready cycle turns into a timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Returns {legal, class} for an RV32I major opcode.
  function automatic logic [4:0] decode_op(input logic [6:0] op);
    logic [4:0] res;
    case (op)
      7'b0110011: res = {1'b1, CLS_R};
      7'b0010011: res = {1'b1, CLS_I};
      7'b0000011: res = {1'b1, CLS_LOAD};
      7'b0100011: res = {1'b1, CLS_STORE};
      7'b1100011: res = {1'b1, CLS_BRANCH};
      7'b0110111: res = {1'b1, CLS_LUI};
      7'b0010111: res = {1'b1, CLS_AUIPC};
      7'b1101111: res = {1'b1, CLS_JAL};
      7'b1100111: res = {1'b1, CLS_JALR};
      default:    res = {1'b0, CLS_R};
    endcase
    return res;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      instr_count_q, instr_count_d;

  logic             retire_s;
  logic [4:0]       dec_s;
  logic             ifetch_s;
  logic             mem_read_s;
  logic             mem_write_s;

  assign dec_s = decode_op(opcode);

  // Next-state, strobe and bookkeeping logic for the whole FSM.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    retire_s    = 1'b0;
    ifetch_s    = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 1'b0;
    reg_write   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        ifetch_s   = 1'b1;
        mem_read_s = 1'b1;
        // A ready on the final allowed cycle still completes the fetch.
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_DECODE: begin
        if (dec_s[4]) begin
          cls_d   = dec_s[3:0];
          state_d = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_EXECUTE: begin
        case (cls_q)
          CLS_BRANCH: begin
            pc_write = 1'b1;
            pc_sel   = take_branch;
            retire_s = 1'b1;
          end
          CLS_LOAD, CLS_STORE: begin
            state_d = S_MEMORY;
            cnt_d   = CNT_ZERO;
          end
          default: begin
            state_d = S_WRITEBACK;
          end
        endcase
      end

      S_MEMORY: begin
        if (cls_q == CLS_LOAD) begin
          mem_read_s = 1'b1;
        end else begin
          mem_write_s = 1'b1;
        end
        if (bus.mem_ready) begin
          if (cls_q == CLS_LOAD) begin
            state_d = S_WRITEBACK;
          end else begin
            // Store completes here: no writeback cycle needed.
            pc_write = 1'b1;
            retire_s = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_sel    = (cls_q == CLS_JAL) || (cls_q == CLS_JALR);
        retire_s  = 1'b1;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        // Encoding 7 is never entered; fall back to a clean start.
        state_d = S_IDLE;
      end
    endcase

    // Retire is the only point besides IDLE where run is sampled.
    if (retire_s) begin
      instr_count_d = instr_count_q + 32'd1;
      cnt_d         = CNT_ZERO;
      if (run) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      instr_count_d = instr_count_q;
    end
  end

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cls_q         <= CLS_R;
      cnt_q         <= CNT_ZERO;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      cnt_q         <= cnt_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.ifetch    = ifetch_s;
  assign bus.mem_read  = mem_read_s;
  assign bus.mem_write = mem_write_s;
  assign state         = state_q;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;
  assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed and randomized checks of the multi-cycle sequencer. Each
// instruction is expanded into the list of cycles it should occupy (phase,
// memory ready for that cycle, expected strobes); the list is then played
// against the DUT one cycle at a time.
// Output vector order: {ifetch, mem_read, mem_write, ir_write, pc_write,
// pc_sel, reg_write}.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] O_NONE       = 7'b0000000;
  localparam logic [6:0] O_FETCH_WAIT = 7'b1100000;
  localparam logic [6:0] O_FETCH_RDY  = 7'b1101000;
  localparam logic [6:0] O_LOAD       = 7'b0100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [6:0]  opcode;
  logic        take_branch;
  logic        ir_write, pc_write, pc_sel, reg_write;
  logic [2:0]  state;
  logic        illegal, timeout;
  logic [31:0] instr_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count;
  logic [6:0]  ops [0:8];

  typedef struct {
    logic [2:0] st;
    logic       rdy;
    logic       rn;
    logic [6:0] outs;
  } step_t;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .opcode      (opcode),
    .take_branch (take_branch),
    .bus         (bus),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .reg_write   (reg_write),
    .state       (state),
    .illegal     (illegal),
    .timeout     (timeout),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, check, then let the
  // rising edge advance the DUT.
  task automatic step(input logic [2:0] st, input logic rdy, input logic rn, input logic [6:0] outs);
    @(negedge clk);
    bus.mem_ready = rdy;
    run           = rn;
    #1;
    chk("state", 32'(state), 32'(st));
    chk("strobes", 32'({bus.ifetch, bus.mem_read, bus.mem_write, ir_write, pc_write, pc_sel, reg_write}),
        32'(outs));
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b1; bus.mem_ready = 1'b1; opcode = OP_I;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'({bus.ifetch, bus.mem_read, bus.mem_write, ir_write, pc_write, pc_sel, reg_write}), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_count = 32'd0;
  endtask

  // Expand one legal instruction into its expected cycles and play them.
  // wf/wm = not-ready cycles before the fetch/memory access completes.
  task automatic do_instr(input logic [6:0] op, input int wf, input int wm, input logic tbr, input logic run_after);
    step_t q[$];
    logic  ld, sto, br, jmp;
    ld  = (op == OP_LOAD);
    sto = (op == OP_STORE);
    br  = (op == OP_BRANCH);
    jmp = (op == OP_JAL) || (op == OP_JALR);
    opcode      = op;
    take_branch = tbr;
    for (int i = 0; i <= wf; i++)
      q.push_back('{3'd1, 1'(i == wf), rb(), (i == wf) ? O_FETCH_RDY : O_FETCH_WAIT});
    q.push_back('{3'd2, rb(), rb(), O_NONE});
    if (br) q.push_back('{3'd3, rb(), run_after, {4'b0000, 1'b1, tbr, 1'b0}});
    else    q.push_back('{3'd3, rb(), rb(), O_NONE});
    if (ld || sto) begin
      for (int i = 0; i <= wm; i++)
        q.push_back('{3'd4, 1'(i == wm), (sto && i == wm) ? run_after : rb(),
                      {1'b0, ld, sto, 1'b0, 1'(sto && i == wm), 1'b0, 1'b0}});
    end
    if (!br && !sto) q.push_back('{3'd5, rb(), run_after, {4'b0000, 1'b1, jmp, 1'b1}});
    if (!run_after)  q.push_back('{3'd0, rb(), 1'b1, O_NONE});
    exp_count = exp_count + 32'd1;
    foreach (q[k]) step(q[k].st, q[k].rdy, q[k].rn, q[k].outs);
    #1;
    chk("instr_count", instr_count, exp_count);
  endtask

  initial begin
    int wf, wm;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    reset = 1'b1; run = 1'b0; opcode = OP_I; take_branch = 1'b0; bus.mem_ready = 1'b0;
    exp_count = 32'd0;

    // Basic I-type flow, two back-to-back instructions (8 cycles).
    do_reset();
    step(3'd0, 1'b1, 1'b1, O_NONE);
    do_instr(OP_I, 0, 0, 1'b0, 1'b1);
    do_instr(OP_I, 0, 0, 1'b0, 1'b1);

    // Load with three wait cycles in MEMORY; branches taken / not taken.
    do_instr(OP_LOAD, 0, 3, 1'b0, 1'b1);
    do_instr(OP_BRANCH, 0, 0, 1'b1, 1'b1);
    do_instr(OP_BRANCH, 0, 0, 1'b0, 1'b1);

    // Every class once, zero wait; run dropped at WRITEBACK of the last.
    do_instr(OP_R, 0, 0, 1'b0, 1'b1);
    do_instr(OP_LUI, 0, 0, 1'b0, 1'b1);
    do_instr(OP_AUIPC, 0, 0, 1'b0, 1'b1);
    do_instr(OP_JAL, 0, 0, 1'b0, 1'b1);
    do_instr(OP_JALR, 0, 0, 1'b0, 1'b1);
    do_instr(OP_STORE, 0, 0, 1'b0, 1'b0);
    do_instr(OP_R, 0, 0, 1'b0, 1'b0);

    // Ready arriving on the last allowed cycle beats the timeout.
    do_instr(OP_I, MEM_TIMEOUT - 1, 0, 1'b0, 1'b1);
    do_instr(OP_STORE, 0, MEM_TIMEOUT - 1, 1'b0, 1'b1);
    chk("no_timeout", 32'(timeout), 32'd0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      wf = ($urandom_range(7, 0) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(3, 0));
      wm = ($urandom_range(7, 0) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(3, 0));
      do_instr(ops[$urandom_range(8, 0)], wf, wm, rb(), 1'($urandom_range(3, 0) != 0));
    end

    // Illegal opcode: halt from DECODE, stay halted with run=1.
    opcode = 7'b1111111;
    step(3'd1, 1'b1, 1'b1, O_FETCH_RDY);
    step(3'd2, 1'b1, 1'b1, O_NONE);
    for (int i = 0; i < 3; i++) step(3'd6, rb(), 1'b1, O_NONE);
    chk("illegal_set", 32'(illegal), 32'd1);
    chk("illegal_count", instr_count, exp_count);
    do_reset();

    // Fetch timeout after exactly MEM_TIMEOUT not-ready cycles.
    step(3'd0, 1'b0, 1'b1, O_NONE);
    for (int i = 0; i < MEM_TIMEOUT; i++) step(3'd1, 1'b0, rb(), O_FETCH_WAIT);
    step(3'd6, 1'b1, 1'b1, O_NONE);
    chk("fetch_timeout", 32'(timeout), 32'd1);
    chk("fetch_to_illegal", 32'(illegal), 32'd0);
    do_reset();

    // Load timeout in MEMORY.
    opcode = OP_LOAD;
    step(3'd0, 1'b0, 1'b1, O_NONE);
    step(3'd1, 1'b1, 1'b1, O_FETCH_RDY);
    step(3'd2, 1'b0, 1'b1, O_NONE);
    step(3'd3, 1'b0, 1'b1, O_NONE);
    for (int i = 0; i < MEM_TIMEOUT; i++) step(3'd4, 1'b0, rb(), O_LOAD);
    step(3'd6, 1'b1, 1'b1, O_NONE);
    chk("mem_timeout", 32'(timeout), 32'd1);
    do_reset();

    // Reset in the middle of a store's MEMORY phase.
    step(3'd0, 1'b1, 1'b1, O_NONE);
    do_instr(OP_I, 0, 0, 1'b0, 1'b1);
    opcode = OP_STORE;
    step(3'd1, 1'b1, 1'b1, O_FETCH_RDY);
    step(3'd2, 1'b1, 1'b1, O_NONE);
    step(3'd3, 1'b1, 1'b1, O_NONE);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_store_state", 32'(state), 32'd4);
    chk("mid_store_write", 32'(bus.mem_write), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_count = 32'd0;
    step(3'd0, 1'b0, 1'b0, O_NONE);
    chk("post_rst_count", instr_count, 32'd0);
    chk("post_rst_timeout", 32'(timeout), 32'd0);
    step(3'd0, 1'b1, 1'b1, O_NONE);
    do_instr(OP_LOAD, 1, 1, 1'b0, 1'b0);
    do_instr(OP_STORE, 0, 2, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
